// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, reset PC, NOP encoding, fetch FSM states.
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    // A PC is unusable if it is not word aligned or the word would run past the end of imem.
    function automatic logic pc_is_bad(input logic [31:0] p, input logic [31:0] last_ok);
        return (p[1:0] != 2'b00) || (p > last_ok);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched word plus its PC behind a valid bit.
// flush beats load beats clr; with none asserted the contents hold (stall).
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] in_instr,
    input  logic [W-1:0] in_pc,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc
);

    // Valid bit and payload; payload only changes on a load so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= W'(NOP_INSTR);
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational imem,
// hands words to decode over valid/ready, and halts sticky on a bad PC.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN       = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IMEM_BYTES = 64
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            fetch_fault,
    output logic [31:0]     fetch_count
);

    localparam logic [31:0] LAST_OK = 32'(IMEM_BYTES - 4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_d;
    logic            adv, pc_bad, rd_bad;
    logic            ir_flush, ir_load, ir_clr;

    assign imem_addr = pc_q;
    assign adv       = !id_valid || id_ready;
    assign pc_bad    = pc_is_bad(32'(pc_q), LAST_OK);
    assign rd_bad    = pc_is_bad(32'(redirect_pc), LAST_OK);

    // Next-state, next-PC and IF/ID control; a redirect always wins over fetch/stall.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fault_d  = fetch_fault;
        ir_flush = 1'b0;
        ir_load  = 1'b0;
        ir_clr   = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    ir_flush = 1'b1;
                    pc_d     = redirect_pc;
                    if (rd_bad) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (adv) begin
                    if (!pc_bad) begin
                        ir_load = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end else begin
                        ir_clr  = 1'b1;
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    ir_flush = 1'b1;
                    pc_d     = redirect_pc;
                    if (!rd_bad) begin
                        state_d = RUN;
                        fault_d = 1'b0;
                    end
                end else if (adv) begin
                    ir_clr = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // PC, FSM state, sticky fault and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= XLEN'(RESET_PC);
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_fault <= fault_d;
            if (id_valid && id_ready)
                fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg #(.W(XLEN)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (ir_flush),
        .load     (ir_load),
        .clr      (ir_clr),
        .in_instr (imem_rdata),
        .in_pc    (pc_q),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc)
    );

endmodule
